// File: rtl/sim_run_ctrl_if.sv
// Request/acknowledge pairs between the run sequencer and the DPI/socket bridge.
// The sequencer drives the requests (master); the bridge answers with acks (slave).
interface sim_run_ctrl_if;
    logic eos_req;
    logic eos_ack;
    logic close_req;
    logic close_ack;

    // Requests are levels held until the matching ack is sampled or the wait times out.
    modport master (output eos_req, output close_req, input eos_ack, input close_ack);
    modport slave  (input eos_req, input close_req, output eos_ack, output close_ack);
endinterface

// File: rtl/sim_run_ctrl.sv
// Co-simulation run sequencer: holds the DUT in reset, runs it for a bounded
// number of cycles, counts benchmark events, then closes down the socket bridge.
module sim_run_ctrl #(
    parameter int unsigned RST_CYCLES  = 11,
    parameter int unsigned RUN_CYCLES  = 200000,
    parameter int unsigned CYC_W       = 32,
    parameter int unsigned EVT_W       = 64,
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic               clk_i,
    input  logic               reset_n,
    input  logic               start,
    input  logic               is_master,
    input  logic               benchmark_event,
    sim_run_ctrl_if.master     bridge,
    output logic               dut_reset_n,
    output logic [CYC_W-1:0]   clk_cnt,
    output logic [EVT_W-1:0]   evt_cnt,
    output logic               finish,
    output logic               done,
    output logic               timeout_err,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_RUN   = 3'd2,
        S_EOS   = 3'd3,
        S_CLOSE = 3'd4,
        S_FIN   = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    // One phase counter serves RST, RUN and both ack waits; size it for the longest.
    localparam int unsigned PH_MAX0 = (RST_CYCLES > RUN_CYCLES) ? RST_CYCLES : RUN_CYCLES;
    localparam int unsigned PH_MAX  = (PH_MAX0 > ACK_TIMEOUT) ? PH_MAX0 : ACK_TIMEOUT;
    localparam int unsigned PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0] RST_LAST = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0] RUN_LAST = PH_W'(RUN_CYCLES - 1);
    localparam logic [PH_W-1:0] ACK_LAST = PH_W'(ACK_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [CYC_W-1:0]   clk_cnt_q, clk_cnt_d;
    logic [EVT_W-1:0]   evt_cnt_q, evt_cnt_d;
    logic               evt_q;
    logic               timeout_q, timeout_d;

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            clk_cnt_q <= '0;
            evt_cnt_q <= '0;
            evt_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            clk_cnt_q <= clk_cnt_d;
            evt_cnt_q <= evt_cnt_d;
            evt_q     <= benchmark_event;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        clk_cnt_d = clk_cnt_q;
        evt_cnt_d = evt_cnt_q;
        timeout_d = timeout_q;

        if (state_q != S_IDLE && state_q != S_DONE && clk_cnt_q != '1)
            clk_cnt_d = clk_cnt_q + CYC_W'(1);
        if (state_q == S_RUN && benchmark_event && !evt_q && evt_cnt_q != '1)
            evt_cnt_d = evt_cnt_q + EVT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RST;
                    phase_d = '0;
                end
            end
            S_RST: begin
                if (phase_q == RST_LAST) begin
                    state_d = S_RUN;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_RUN: begin
                if (phase_q == RUN_LAST) begin
                    state_d = is_master ? S_EOS : S_FIN;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            // An ack on the last allowed cycle still wins over the timeout.
            S_EOS: begin
                if (bridge.eos_ack || phase_q == ACK_LAST) begin
                    state_d = S_CLOSE;
                    phase_d = '0;
                    if (!bridge.eos_ack) timeout_d = 1'b1;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_CLOSE: begin
                if (bridge.close_ack || phase_q == ACK_LAST) begin
                    state_d = S_FIN;
                    phase_d = '0;
                    if (!bridge.close_ack) timeout_d = 1'b1;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_FIN:   state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    assign dut_reset_n      = (state_q != S_IDLE) && (state_q != S_RST);
    assign bridge.eos_req   = (state_q == S_EOS);
    assign bridge.close_req = (state_q == S_CLOSE);
    assign finish           = (state_q == S_FIN);
    assign done             = (state_q == S_DONE);
    assign clk_cnt          = clk_cnt_q;
    assign evt_cnt          = evt_cnt_q;
    assign timeout_err      = timeout_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: three instances cover default-width runs, counter
// saturation and the one-cycle RST/RUN limits, all against a run-level model.
module tb_sim_run_ctrl;

    localparam int unsigned A_RST = 3, A_RUN = 100, A_TMO = 8, A_CW = 32, A_EW = 64;
    localparam int unsigned B_RST = 1, B_RUN = 40,  B_TMO = 4, B_CW = 4,  B_EW = 3;
    localparam int unsigned C_RST = 2, C_RUN = 1,   C_TMO = 2, C_CW = 8,  C_EW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, start_v, is_master, bev, eos_ack_v, close_ack_v;
    int   sel;
    int   n_chk = 0;
    int   n_err = 0;

    sim_run_ctrl_if if_a ();
    sim_run_ctrl_if if_b ();
    sim_run_ctrl_if if_c ();

    logic              drn_a, fin_a, done_a, to_a;
    logic [2:0]        st_a;
    logic [A_CW-1:0]   clk_a;
    logic [A_EW-1:0]   evt_a;
    logic              drn_b, fin_b, done_b, to_b;
    logic [2:0]        st_b;
    logic [B_CW-1:0]   clk_b;
    logic [B_EW-1:0]   evt_b;
    logic              drn_c, fin_c, done_c, to_c;
    logic [2:0]        st_c;
    logic [C_CW-1:0]   clk_c;
    logic [C_EW-1:0]   evt_c;

    assign if_a.eos_ack   = eos_ack_v   & (sel == 0);
    assign if_a.close_ack = close_ack_v & (sel == 0);
    assign if_b.eos_ack   = eos_ack_v   & (sel == 1);
    assign if_b.close_ack = close_ack_v & (sel == 1);
    assign if_c.eos_ack   = eos_ack_v   & (sel == 2);
    assign if_c.close_ack = close_ack_v & (sel == 2);

    sim_run_ctrl #(.RST_CYCLES(A_RST), .RUN_CYCLES(A_RUN), .CYC_W(A_CW), .EVT_W(A_EW), .ACK_TIMEOUT(A_TMO)) u_a (
        .clk_i(clk), .reset_n(reset_n), .start(start_v & (sel == 0)), .is_master(is_master),
        .benchmark_event(bev), .bridge(if_a), .dut_reset_n(drn_a), .clk_cnt(clk_a), .evt_cnt(evt_a),
        .finish(fin_a), .done(done_a), .timeout_err(to_a), .state_o(st_a));
    sim_run_ctrl #(.RST_CYCLES(B_RST), .RUN_CYCLES(B_RUN), .CYC_W(B_CW), .EVT_W(B_EW), .ACK_TIMEOUT(B_TMO)) u_b (
        .clk_i(clk), .reset_n(reset_n), .start(start_v & (sel == 1)), .is_master(is_master),
        .benchmark_event(bev), .bridge(if_b), .dut_reset_n(drn_b), .clk_cnt(clk_b), .evt_cnt(evt_b),
        .finish(fin_b), .done(done_b), .timeout_err(to_b), .state_o(st_b));
    sim_run_ctrl #(.RST_CYCLES(C_RST), .RUN_CYCLES(C_RUN), .CYC_W(C_CW), .EVT_W(C_EW), .ACK_TIMEOUT(C_TMO)) u_c (
        .clk_i(clk), .reset_n(reset_n), .start(start_v & (sel == 2)), .is_master(is_master),
        .benchmark_event(bev), .bridge(if_c), .dut_reset_n(drn_c), .clk_cnt(clk_c), .evt_cnt(evt_c),
        .finish(fin_c), .done(done_c), .timeout_err(to_c), .state_o(st_c));

    logic [2:0]  o_st;
    logic        o_drn, o_eos, o_close, o_fin, o_done, o_to;
    logic [63:0] o_clk, o_evt;

    always_comb begin
        o_st = '0; o_drn = 1'b0; o_eos = 1'b0; o_close = 1'b0; o_fin = 1'b0;
        o_done = 1'b0; o_to = 1'b0; o_clk = '0; o_evt = '0;
        case (sel)
            0: begin
                o_st = st_a; o_drn = drn_a; o_eos = if_a.eos_req; o_close = if_a.close_req;
                o_fin = fin_a; o_done = done_a; o_to = to_a; o_clk = 64'(clk_a); o_evt = 64'(evt_a);
            end
            1: begin
                o_st = st_b; o_drn = drn_b; o_eos = if_b.eos_req; o_close = if_b.close_req;
                o_fin = fin_b; o_done = done_b; o_to = to_b; o_clk = 64'(clk_b); o_evt = 64'(evt_b);
            end
            default: begin
                o_st = st_c; o_drn = drn_c; o_eos = if_c.eos_req; o_close = if_c.close_req;
                o_fin = fin_c; o_done = done_c; o_to = to_c; o_clk = 64'(clk_c); o_evt = 64'(evt_c);
            end
        endcase
    end

    function automatic int unsigned prm(input int s, input int k);
        int unsigned t [3][5];
        t[0] = '{A_RST, A_RUN, A_TMO, A_CW, A_EW};
        t[1] = '{B_RST, B_RUN, B_TMO, B_CW, B_EW};
        t[2] = '{C_RST, C_RUN, C_TMO, C_CW, C_EW};
        return t[s][k];
    endfunction

    function automatic longint unsigned all_ones(input int unsigned w);
        return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic longint unsigned umin(input longint unsigned a, input longint unsigned b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start_v = 1'b0; bev = 1'b0; eos_ack_v = 1'b0; close_ack_v = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk({tag, "_state"}, 64'(o_st), 64'd0);
            chk({tag, "_drn"},   64'(o_drn), 64'd0);
            chk({tag, "_clk"},   o_clk, 64'd0);
            chk({tag, "_evt"},   o_evt, 64'd0);
            chk({tag, "_req"},   64'({o_eos, o_close, o_fin, o_done, o_to}), 64'd0);
        end
    endtask

    // One full sequence from start to DONE; ev_mode 0=quiet, 1=random, 2=2-high/2-low toggle.
    task automatic run_and_check(input string tag, input bit master, input int eos_d,
                                 input int close_d, input int ev_mode);
        int unsigned R, N, T, CW, EW;
        bit ev_hist[$];
        int rst_low, run_n, eos_c, close_c, fin_n;
        bit got_done;
        int unsigned evt_edges;
        longint unsigned exp_eos, exp_close, exp_clk, exp_evt;
        logic [63:0] clk_hold, evt_hold;
        R = prm(sel, 0); N = prm(sel, 1); T = prm(sel, 2); CW = prm(sel, 3); EW = prm(sel, 4);
        rst_low = 0; run_n = 0; eos_c = 0; close_c = 0; fin_n = 0; got_done = 1'b0;
        is_master = master;
        start_v = 1'b1;
        for (int j = 0; j < 3000 && !got_done; j++) begin
            case (ev_mode)
                0:       bev = 1'b0;
                1:       bev = 1'($urandom_range(0, 1));
                default: bev = (((j / 2) % 2) == 1);
            endcase
            ev_hist.push_back(bev);
            @(posedge clk);
            @(negedge clk);
            start_v = 1'b0;
            if (!o_drn) rst_low++;
            if (o_st == 3'd2) run_n++;
            if (o_fin) fin_n++;
            if (o_done) got_done = 1'b1;
            // Acks respond to the request; while it is low they carry random noise.
            if (o_eos) begin
                eos_ack_v = (eos_c >= eos_d);
                eos_c++;
            end else begin
                eos_ack_v = 1'($urandom_range(0, 1));
            end
            if (o_close) begin
                close_ack_v = (close_c >= close_d);
                close_c++;
            end else begin
                close_ack_v = 1'($urandom_range(0, 1));
            end
        end
        chk({tag, "_reached_done"}, 64'(got_done), 64'd1);

        evt_edges = 0;
        for (int j = R + 1; j <= R + N && j < ev_hist.size(); j++)
            if (ev_hist[j] && !ev_hist[j-1]) evt_edges++;
        exp_eos   = master ? umin(longint'(eos_d) + 1, T) : 0;
        exp_close = master ? umin(longint'(close_d) + 1, T) : 0;
        exp_clk   = umin(R + N + exp_eos + exp_close + 1, all_ones(CW));
        exp_evt   = umin(evt_edges, all_ones(EW));

        chk({tag, "_rst_low"},   64'(rst_low), 64'(R));
        chk({tag, "_run_len"},   64'(run_n), 64'(N));
        chk({tag, "_eos_len"},   64'(eos_c), exp_eos);
        chk({tag, "_close_len"}, 64'(close_c), exp_close);
        chk({tag, "_timeout"},   64'(o_to), 64'(master && (eos_d >= int'(T) || close_d >= int'(T))));
        chk({tag, "_clk_cnt"},   o_clk, exp_clk);
        chk({tag, "_evt_cnt"},   o_evt, exp_evt);

        // DONE must ignore start and events and keep everything frozen.
        clk_hold = o_clk; evt_hold = o_evt;
        for (int k = 0; k < 6; k++) begin
            start_v = 1'($urandom_range(0, 1));
            bev = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (o_fin) fin_n++;
        end
        start_v = 1'b0;
        chk({tag, "_finish_once"}, 64'(fin_n), 64'd1);
        chk({tag, "_done_state"},  64'({o_st, o_done, o_drn}), 64'({3'd6, 1'b1, 1'b1}));
        chk({tag, "_clk_frozen"},  o_clk, clk_hold);
        chk({tag, "_evt_frozen"},  o_evt, evt_hold);
    endtask

    initial begin
        sel = 0; is_master = 1'b0;
        do_reset();
        chk_reset_state("rst0");
        repeat (3) @(negedge clk);
        chk("idle_hold", 64'({st_a, st_b, st_c}), 64'd0);

        sel = 0; run_and_check("a_slave_quiet", 1'b0, 0, 0, 0);
        do_reset(); sel = 0; run_and_check("a_slave_toggle", 1'b0, 0, 0, 2);
        chk("a_toggle_25", o_evt, 64'd25);
        do_reset(); sel = 0; run_and_check("a_master_ack", 1'b1, 3, 0, 1);
        do_reset(); sel = 0; run_and_check("a_eos_timeout", 1'b1, 1000, 2, 1);

        // Reset while the EOS request is up, then a clean restart.
        do_reset(); sel = 0; is_master = 1'b1; start_v = 1'b1;
        for (int j = 0; j < 300 && o_st != 3'd3; j++) begin
            @(negedge clk);
            start_v = 1'b0;
        end
        start_v = 1'b0;
        chk("mid_eos_reached", 64'(o_eos), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk_reset_state("mid_eos_rst");
        sel = 0; run_and_check("a_restart", 1'b1, 1, 5, 1);

        for (int r = 0; r < 3; r++) begin
            do_reset(); sel = 0;
            run_and_check($sformatf("a_rand%0d", r), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 10)), int'($urandom_range(0, 10)), 1);
        end

        do_reset(); sel = 1; run_and_check("b_sat", 1'b1, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 1);
        chk("b_clk_sat", o_clk, 64'd15);
        do_reset(); sel = 2; run_and_check("c_min_slave", 1'b0, 0, 0, 1);
        do_reset(); sel = 2; run_and_check("c_min_master", 1'b1, 0, 3, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
Run sequencer for a co-simulation target top.
- Holds the DUT in reset for a fixed number of cycles, then runs it for a bounded number of cycles.
- Counts rising edges of the DUT's benchmark_event during the run.
- On run end, the master side sends end-of-simulation and socket-close requests to the socket bridge, with ack timeouts; every side then raises a one-cycle finish pulse.
- Sits between the clock source, the DUT and the DPI/socket bridge; replaces ad-hoc counters in the sim top.

Parameters:
RST_CYCLES, 11, cycles dut_reset_n is held low after start (1..2^16-1)
RUN_CYCLES, 200000, cycles in RUN state before end-of-sim (>=1)
CYC_W, 32, width of cycle counter
EVT_W, 64, width of event counter
ACK_TIMEOUT, 1024, max cycles waiting for eos_ack / close_ack (>=1)

Ports:
clk_i  input  1  sole clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  level; sampled in IDLE to begin sequence
is_master  input  1  1 = this side sends EOS and closes socket; sampled on leaving RUN
benchmark_event  input  1  DUT event strobe/level; rising edges counted
eos_ack  input  1  bridge acknowledges EOS request
close_ack  input  1  bridge acknowledges socket close
dut_reset_n  output  1  reset to DUT, active-low
clk_cnt  output  CYC_W  cycles elapsed since leaving IDLE
evt_cnt  output  EVT_W  benchmark_event rising edges seen in RUN
eos_req  output  1  level request to send EOS signal
close_req  output  1  level request to close parent socket
finish  output  1  one-cycle pulse; sim top calls $finish on it
done  output  1  sticky, high in DONE
timeout_err  output  1  sticky, set if any ack timed out
state_o  output  3  current state encoding (debug)

Behaviour:
Reset (reset_n low at a clk_i edge):
- State goes to IDLE.
- dut_reset_n=0, clk_cnt=0, evt_cnt=0, eos_req=0, close_req=0, finish=0, done=0, timeout_err=0.
- Internal edge register=0, phase counter=0.
- Applies from any state, including mid-handshake; requests drop the next edge.

States, encoded on state_o as IDLE=0, RST=1, RUN=2, EOS=3, CLOSE=4, FIN=5, DONE=6:
- IDLE: dut_reset_n=0. If start=1, go to RST; clk_cnt begins counting the cycle after.
- RST: dut_reset_n=0. After RST_CYCLES cycles in RST, go to RUN; dut_reset_n=1 from the first RUN cycle.
- RUN: dut_reset_n=1. After RUN_CYCLES cycles in RUN, go to EOS if is_master=1, else to FIN.
- EOS: eos_req=1 from entry, held until eos_ack=1 is sampled. Then eos_req=0 on the next edge and go to CLOSE. If ACK_TIMEOUT cycles pass with no ack: set timeout_err, drop eos_req, go to CLOSE.
- CLOSE: same handshake as EOS using close_req/close_ack; exit to FIN.
- FIN: finish=1 for exactly one cycle, then go to DONE.
- DONE: done=1, dut_reset_n stays 1, all counters frozen. start is ignored; leave DONE only via reset_n.

Counters:
- clk_cnt increments every cycle outside IDLE and DONE.
- clk_cnt saturates at all-ones; it does not wrap.

Event counting:
- Rising-edge detect: benchmark_event=1 and the previous sampled value=0.
- Count only while in RUN, including the final RUN cycle. Edges in RST, EOS, CLOSE, FIN and DONE are ignored, but the edge register still updates.
- The edge register is cleared by reset, so a benchmark_event held high out of reset counts once when first sampled in RUN only if it was 0 at the previous sample.
- evt_cnt saturates at all-ones.

Handshake details:
- An ack already high on the EOS/CLOSE entry cycle is accepted that cycle; the request is visible for one cycle.
- Ack while the corresponding request is low is ignored.
- Timeout counter restarts at 0 on each EOS/CLOSE entry.

Counter-limit boundaries:
- RST_CYCLES=1: exactly one RST cycle.
- RUN_CYCLES=1: exactly one RUN cycle.

Test Plan:
- Defaults, start=1 at cycle 0, is_master=0, no events -> dut_reset_n low 11 cycles after start, RUN 200000 cycles, finish pulse once, done=1, eos_req/close_req never high, evt_cnt=0.
- RUN_CYCLES=100, benchmark_event toggled every 4 cycles (2 high, 2 low) in RUN -> evt_cnt=25; same toggling during RST adds 0.
- is_master=1, eos_ack after 3 cycles, close_ack same cycle as entry -> eos_req high 4 cycles, close_req high 1 cycle, finish 1 cycle after CLOSE exit, timeout_err=0.
- is_master=1, ACK_TIMEOUT=8, eos_ack never -> eos_req high 8 cycles, timeout_err=1, proceeds to CLOSE, close_ack honored, finish still pulses once.
- reset_n low for 1 cycle while in EOS with eos_req=1 -> next cycle state_o=0, eos_req=0, counters 0; restart with start completes normally.
- CYC_W=4, RUN_CYCLES=40 -> clk_cnt holds at 15 without wrap; DONE reached; start pulses in DONE have no effect.
